// File: rtl/counter4_pkg.sv
// counter4_pkg: shared state encoding and default sizing for the counter sequencer.
package counter4_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam int DEF_WIDTH    = 2;
    localparam int DEF_PRESCALE = 4;
endpackage

// File: rtl/counter4_prescaler.sv
// counter4_prescaler: divides clk by PRESCALE; advances only while enabled and not held.
module counter4_prescaler
    import counter4_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_hold,
    input  logic i_clear,
    output logic o_tick
);
    localparam int PS_W = $clog2(PRESCALE) > 0 ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
    logic [PS_W-1:0] r_ps;
    logic            w_adv;
    assign w_adv  = i_en && !i_hold;
    assign o_tick = w_adv && (r_ps == PS_MAX);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ps <= '0;
        else if (i_clear)
            r_ps <= '0;
        else if (w_adv)
            r_ps <= (r_ps == PS_MAX) ? '0 : r_ps + PS_W'(1);
    end
endmodule

// File: rtl/counter4_ctrl.sv
// counter4_ctrl: run/pause/stop sequencer owning the count register, with one-shot
// or auto-reload termination at a terminal value latched when a run starts.
module counter4_ctrl
    import counter4_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             reload,
    input  logic [WIDTH-1:0] tc_value,
    output logic             cnt_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_count, r_tc;
    logic             r_reload, r_done;
    logic             w_launch, w_tick, w_term;
    assign w_launch = start && !stop && (r_state == IDLE || r_state == DONE);
    assign w_term   = w_tick && (r_count == r_tc);
    // stop folds into hold so the tick is suppressed on the aborting edge
    counter4_prescaler #(.PRESCALE(PRESCALE)) u_ps (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_state == RUN),
        .i_hold (pause || stop),
        .i_clear(stop || w_launch),
        .o_tick (w_tick)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        cnt_en = w_tick;
        busy   = (r_state == RUN) || (r_state == PAUSE);
        if (stop)
            w_next = IDLE;
        else if (w_launch)
            w_next = RUN;
        else if (r_state == RUN && pause)
            w_next = PAUSE;
        else if (r_state == PAUSE && !pause)
            w_next = RUN;
        else if (w_term && !r_reload)
            w_next = DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_tc     <= '0;
            r_reload <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_term;
            if (stop || w_launch)
                r_count <= '0;
            else if (w_term)
                r_count <= r_reload ? '0 : r_count;
            else if (w_tick)
                r_count <= r_count + WIDTH'(1);
            if (w_launch) begin
                r_tc     <= tc_value;
                r_reload <= reload;
            end
        end
    end
    assign count = r_count;
    assign done  = r_done;
    assign state = r_state;
endmodule

// File: tb/tb_counter4_ctrl.sv
// tb_counter4_ctrl: directed scenarios for counter4_ctrl (PRESCALE=4 and PRESCALE=1 builds).
module tb_counter4_ctrl;
    logic       clk, rst_n;
    logic       start, stop, pause, reload;
    logic [1:0] tc_value;
    logic       cnt_en, busy, done;
    logic [1:0] count, state;
    logic       start1, stop1, reload1;
    logic [1:0] tc1;
    logic       cnt_en1, busy1, done1;
    logic [1:0] count1, state1;
    int         errors = 0;
    int         checks = 0;

    counter4_ctrl #(.WIDTH(2), .PRESCALE(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .reload(reload), .tc_value(tc_value), .cnt_en(cnt_en), .count(count),
        .busy(busy), .done(done), .state(state)
    );
    counter4_ctrl #(.WIDTH(2), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .pause(1'b0),
        .reload(reload1), .tc_value(tc1), .cnt_en(cnt_en1), .count(count1),
        .busy(busy1), .done(done1), .state(state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(2);
        checks += 5;
        if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        if (cnt_en !== 1'b0) begin errors++; $display("FAIL reset_cnt_en got %0b exp 0", cnt_en); end
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_one_shot();
        tc_value = 2'd2; reload = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        checks += 3;
        if (state !== 2'd1) begin errors++; $display("FAIL os_start_state got %0d exp 1", state); end
        if (busy !== 1'b1) begin errors++; $display("FAIL os_start_busy got %0b exp 1", busy); end
        if (count !== 2'd0) begin errors++; $display("FAIL os_start_count got %0d exp 0", count); end
        cyc(3);
        checks++;
        if (cnt_en !== 1'b1) begin errors++; $display("FAIL os_tick3 got %0b exp 1", cnt_en); end
        cyc(1);
        checks += 2;
        if (count !== 2'd1) begin errors++; $display("FAIL os_edge4_count got %0d exp 1", count); end
        if (cnt_en !== 1'b0) begin errors++; $display("FAIL os_edge4_cnt_en got %0b exp 0", cnt_en); end
        cyc(4);
        checks++;
        if (count !== 2'd2) begin errors++; $display("FAIL os_edge8_count got %0d exp 2", count); end
        cyc(3);
        checks += 2;
        if (cnt_en !== 1'b1) begin errors++; $display("FAIL os_edge11_cnt_en got %0b exp 1", cnt_en); end
        if (done !== 1'b0) begin errors++; $display("FAIL os_edge11_done got %0b exp 0", done); end
        cyc(1);
        checks += 4;
        if (state !== 2'd3) begin errors++; $display("FAIL os_edge12_state got %0d exp 3", state); end
        if (count !== 2'd2) begin errors++; $display("FAIL os_edge12_count got %0d exp 2", count); end
        if (done !== 1'b1) begin errors++; $display("FAIL os_edge12_done got %0b exp 1", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL os_edge12_busy got %0b exp 0", busy); end
        cyc(1);
        checks += 3;
        if (done !== 1'b0) begin errors++; $display("FAIL os_edge13_done got %0b exp 0", done); end
        if (state !== 2'd3) begin errors++; $display("FAIL os_edge13_state got %0d exp 3", state); end
        if (count !== 2'd2) begin errors++; $display("FAIL os_edge13_count got %0d exp 2", count); end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        checks += 2;
        if (state !== 2'd0) begin errors++; $display("FAIL os_stop_state got %0d exp 0", state); end
        if (count !== 2'd0) begin errors++; $display("FAIL os_stop_count got %0d exp 0", count); end
    endtask

    task automatic test_reload();
        tc_value = 2'd3; reload = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc(4);
            checks += 3;
            if (count !== 2'(k % 4)) begin errors++; $display("FAIL rl_count k=%0d got %0d exp %0d", k, count, k % 4); end
            if (done !== (k % 4 == 0)) begin errors++; $display("FAIL rl_done k=%0d got %0b exp %0b", k, done, k % 4 == 0); end
            if (state !== 2'd1) begin errors++; $display("FAIL rl_state k=%0d got %0d exp 1", k, state); end
        end
        cyc(1);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rl_done_width got %0b exp 0", done); end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        tc_value = 2'd3; reload = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(6);
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (state !== 2'd0) begin errors++; $display("FAIL ar_state got %0d exp 0", state); end
        if (count !== 2'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", count); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %0b exp 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL ar_done got %0b exp 0", done); end
        if (cnt_en !== 1'b0) begin errors++; $display("FAIL ar_cnt_en got %0b exp 0", cnt_en); end
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_pause();
        tc_value = 2'd3; reload = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(6);
        pause = 1'b1;
        checks++;
        if (cnt_en !== 1'b0) begin errors++; $display("FAIL ps_enter_cnt_en got %0b exp 0", cnt_en); end
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            checks += 3;
            if (count !== 2'd1) begin errors++; $display("FAIL ps_count i=%0d got %0d exp 1", i, count); end
            if (cnt_en !== 1'b0) begin errors++; $display("FAIL ps_cnt_en i=%0d got %0b exp 0", i, cnt_en); end
            if (state !== 2'd2) begin errors++; $display("FAIL ps_state i=%0d got %0d exp 2", i, state); end
        end
        pause = 1'b0;
        cyc(1);
        checks += 2;
        if (state !== 2'd1) begin errors++; $display("FAIL ps_resume_state got %0d exp 1", state); end
        if (cnt_en !== 1'b0) begin errors++; $display("FAIL ps_resume1_cnt_en got %0b exp 0", cnt_en); end
        cyc(1);
        checks++;
        if (cnt_en !== 1'b1) begin errors++; $display("FAIL ps_resume2_cnt_en got %0b exp 1", cnt_en); end
        cyc(1);
        checks++;
        if (count !== 2'd2) begin errors++; $display("FAIL ps_resume_count got %0d exp 2", count); end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic test_conflicts();
        tc_value = 2'd3; reload = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(5);
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        checks += 3;
        if (state !== 2'd0) begin errors++; $display("FAIL cf_both_state got %0d exp 0", state); end
        if (count !== 2'd0) begin errors++; $display("FAIL cf_both_count got %0d exp 0", count); end
        if (done !== 1'b0) begin errors++; $display("FAIL cf_both_done got %0b exp 0", done); end
        cyc(1);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL cf_both_done_next got %0b exp 0", done); end
        tc_value = 2'd1; start = 1'b1;
        cyc(1);
        start = 1'b0; tc_value = 2'd0;
        cyc(2);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        checks += 3;
        if (count !== 2'd1) begin errors++; $display("FAIL cf_relatch_count got %0d exp 1", count); end
        if (state !== 2'd1) begin errors++; $display("FAIL cf_relatch_state got %0d exp 1", state); end
        if (done !== 1'b0) begin errors++; $display("FAIL cf_relatch_done got %0b exp 0", done); end
        cyc(4);
        checks += 3;
        if (state !== 2'd3) begin errors++; $display("FAIL cf_end_state got %0d exp 3", state); end
        if (count !== 2'd1) begin errors++; $display("FAIL cf_end_count got %0d exp 1", count); end
        if (done !== 1'b1) begin errors++; $display("FAIL cf_end_done got %0b exp 1", done); end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic test_edge_configs();
        tc_value = 2'd0; reload = 1'b0; start = 1'b1;
        cyc(1);
        cyc(3);
        checks++;
        if (cnt_en !== 1'b1) begin errors++; $display("FAIL tc0_cnt_en got %0b exp 1", cnt_en); end
        cyc(1);
        checks += 3;
        if (state !== 2'd3) begin errors++; $display("FAIL tc0_state got %0d exp 3", state); end
        if (count !== 2'd0) begin errors++; $display("FAIL tc0_count got %0d exp 0", count); end
        if (done !== 1'b1) begin errors++; $display("FAIL tc0_done got %0b exp 1", done); end
        cyc(1);
        start = 1'b0;
        checks += 3;
        if (state !== 2'd1) begin errors++; $display("FAIL held_restart_state got %0d exp 1", state); end
        if (count !== 2'd0) begin errors++; $display("FAIL held_restart_count got %0d exp 0", count); end
        if (done !== 1'b0) begin errors++; $display("FAIL held_restart_done got %0b exp 0", done); end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        tc1 = 2'd3; reload1 = 1'b1; start1 = 1'b1;
        cyc(1);
        start1 = 1'b0;
        checks += 2;
        if (state1 !== 2'd1) begin errors++; $display("FAIL p1_state got %0d exp 1", state1); end
        if (cnt_en1 !== 1'b1) begin errors++; $display("FAIL p1_cnt_en0 got %0b exp 1", cnt_en1); end
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            checks += 3;
            if (count1 !== 2'(k % 4)) begin errors++; $display("FAIL p1_count k=%0d got %0d exp %0d", k, count1, k % 4); end
            if (cnt_en1 !== 1'b1) begin errors++; $display("FAIL p1_cnt_en k=%0d got %0b exp 1", k, cnt_en1); end
            if (done1 !== (k == 4)) begin errors++; $display("FAIL p1_done k=%0d got %0b exp %0b", k, done1, k == 4); end
        end
        stop1 = 1'b1;
        cyc(1);
        stop1 = 1'b0;
    endtask

    initial begin
        start = 1'b0; stop = 1'b0; pause = 1'b0; reload = 1'b0; tc_value = 2'd0;
        start1 = 1'b0; stop1 = 1'b0; reload1 = 1'b0; tc1 = 2'd0;
        test_reset();
        test_one_shot();
        test_reload();
        test_async_reset();
        test_pause();
        test_conflicts();
        test_edge_configs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter4_ctrl.md
Name: counter4_ctrl

Overview:
Sequencer for the 2-bit practice counter datapath. It divides `clk` with a programmable prescaler and issues count-enable ticks. It owns the count register, stops at or reloads from a latched terminal value, and reports status. It sits between board-level controls (buttons/switches, synchronised upstream) and the LED/display logic.

Parameters:
- WIDTH, 2, count register width in bits.
- PRESCALE, 4, clk cycles per count tick; legal range ≥1.
- PS_W, $clog2(PRESCALE)>0 ? $clog2(PRESCALE) : 1, prescaler width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled per cycle; begins a run from IDLE or DONE.
- stop  in  1  level; abort to IDLE; highest priority.
- pause  in  1  level; while high in RUN/PAUSE, the count is frozen.
- reload  in  1  mode, latched at start: 0 = one-shot, 1 = auto-reload.
- tc_value  in  WIDTH  terminal count, latched at start.
- cnt_en  out  1  combinational tick; high in the cycle before the edge where count advances.
- count  out  WIDTH  count register.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  registered one-cycle pulse after each terminal event.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (async, immediate, no clock needed):
  - state=IDLE, count=0, prescaler=0, done=0.
  - tc_latched=0, reload_latched=0; cnt_en=0, busy=0.
  - Reset asserted mid-run aborts the run with no done pulse.
- Priority per cycle: stop > start > pause.
- IDLE / DONE:
  - start → RUN; count=0, prescaler=0; tc_value and reload are latched.
  - Otherwise hold. count keeps its value in DONE and is 0 in IDLE.
- tick = (state==RUN) && !pause && !stop && (prescaler==PRESCALE-1). cnt_en = tick.
- RUN, per cycle:
  - prescaler increments and wraps to 0 at PRESCALE-1.
  - PRESCALE=1: prescaler constant 0, so tick is high every RUN cycle.
  - On a tick edge with count != tc_latched: count = count+1.
  - On a tick edge with count == tc_latched (terminal event):
    - one-shot: count holds at tc, state → DONE.
    - reload: count → 0, stay RUN.
  - done pulses high in the cycle after every terminal edge.
  - Run period = (tc_latched+1)·PRESCALE cycles. tc=0 gives a terminal on the first tick.
  - pause high → PAUSE; the prescaler is not advanced on that edge.
- PAUSE:
  - prescaler and count frozen.
  - pause low → RUN; the prescaler resumes from the held value, so no tick is lost or added.
- stop in any state → IDLE; count=0, prescaler=0; no done pulse.
- start in RUN/PAUSE is ignored; tc_value/reload changes there are not re-latched.
- start and stop high together → stop wins (IDLE).
- start held high in DONE restarts on the next edge. start held high continuously after a one-shot gives DONE for 1 cycle, then RUN again.
- count arithmetic is modulo 2^WIDTH, but never exceeds tc_latched. Overflow is therefore impossible for any legal tc.
- All outputs except cnt_en are registered or decoded from registered state only.

Decomposition:
- Package counter4_pkg:
  - state enum/localparams IDLE/RUN/PAUSE/DONE (2-bit encoding above).
  - default WIDTH and PRESCALE constants.
- One natural sub-module: counter4_prescaler (enable, hold, clear inputs; tick output).
- FSM and count register stay in counter4_ctrl.

Test Plan (WIDTH=2, PRESCALE=4):
1. Reset: hold rst_n=0 then release → state=0, count=0, busy=0, done=0, cnt_en=0. Assert rst_n=0 asynchronously mid-RUN → same values before the next clk edge.
2. One-shot, tc=2, start pulsed at edge 0:
   - count=1 at edge 4, count=2 at edge 8.
   - terminal at edge 12 → state=DONE and count=2 (count not incremented past tc).
   - done=1 for exactly one cycle after edge 12; busy falls at edge 12.
3. Reload, tc=3: count sequence 0,1,2,3,0,… changing every 4 cycles; done pulses every 16 cycles; state stays RUN.
4. Pause: raise pause for 10 cycles when prescaler=2, count=1 → count frozen and cnt_en=0 throughout. After release, the next tick comes 2 cycles later (prescaler resumes at 2).
5. Control conflicts:
   - start=1 and stop=1 together in RUN → IDLE, count=0, no done.
   - start with tc_value changed to 0 during RUN → ignored; the run ends at the original tc.
6. Edge configs:
   - tc=0 one-shot → done after 4 cycles, count=0.
   - PRESCALE=1 build → cnt_en continuously high in RUN; count advances every cycle.
